hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline control counterpart to the operand-forwarding unit in the LC-3b 5-stage pipeline.
- Where forwarding cannot supply a value, or the pipeline must not advance, this block stalls, bubbles, freezes or flushes the stages. Cases covered: load-use hazard, instruction/data memory wait, taken-branch flush.
- It owns the drain state for a stale in-flight fetch after a flush, and keeps saturating stall/flush performance counters.

Parameters:
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ID_EX_opcode  in  lc3b_opcode  opcode of the instruction in ID/EX
ID_EX_regwrite  in  1  ID/EX instruction writes a register
ID_EX_dest  in  lc3b_reg  destination of the ID/EX instruction
IF_ID_sr1  in  lc3b_reg  source 1 of the decoding instruction
IF_ID_sr2  in  lc3b_reg  source 2 of the decoding instruction
IF_ID_uses_sr1  in  1  decoding instruction reads sr1
IF_ID_uses_sr2  in  1  decoding instruction reads sr2 (ADD/AND with bit5=0, stores)
EX_MEM_mem_access  in  1  EX/MEM instruction reads or writes data memory
dmem_resp  in  1  data memory access complete this cycle
imem_resp  in  1  instruction fetch complete this cycle
EX_MEM_br_taken  in  1  resolved taken branch/jump/trap in EX/MEM
perf_clr  in  1  synchronous clear of both counters
freeze_all  out  1  every pipeline register and the PC hold
pc_stall  out  1  PC holds
if_id_stall  out  1  IF/ID holds
if_id_bubble  out  1  IF/ID loads a NOP
id_ex_bubble  out  1  ID/EX loads a NOP
flush_ex  out  1  ID/EX loads a NOP due to a flush
stall_cycles  out  CNT_WIDTH  cycles with freeze_all or pc_stall
flush_count  out  CNT_WIDTH  taken-branch flushes performed

Behaviour:
- Outputs are combinational from state and inputs; the state and counters are registered.
- Reset (async, reset_n=0): state=RUN, counters=0. While in reset, all control outputs are 0.
- load = ID_EX_opcode in {op_ldb, op_ldr, op_ldi}.
- luhaz = load & ID_EX_regwrite & ((IF_ID_uses_sr1 & ID_EX_dest==IF_ID_sr1) | (IF_ID_uses_sr2 & ID_EX_dest==IF_ID_sr2)).
- dwait = EX_MEM_mem_access & !dmem_resp.
- Priority, in state RUN, highest first:
  1. dwait: freeze_all=1, pc_stall=1, all other outputs 0. A pending branch or hazard is not acted on. Stay RUN.
  2. EX_MEM_br_taken: if_id_bubble=1, flush_ex=1, PC loads the target (pc_stall=0). flush_count increments. If imem_resp=0, go to DRAIN; otherwise stay RUN.
  3. luhaz: pc_stall=1, if_id_stall=1, id_ex_bubble=1, for exactly one cycle. Next cycle ID/EX holds the bubble, so there is no re-detection and the load's value reaches the forwarding path from MEM/WB.
  4. !imem_resp: pc_stall=1, if_id_bubble=1; downstream stages advance.
  5. Otherwise all outputs 0.
- State DRAIN: the stale fetch from before the flush is still outstanding, and imem holds its address until the response arrives.
  - If dwait: freeze_all=1, pc_stall=1; stay in DRAIN.
  - Else: pc_stall=1, if_id_bubble=1. The stale response is discarded.
  - On imem_resp=1 with no dwait, go to RUN next cycle.
  - A branch in EX/MEM cannot occur in DRAIN (flush_ex emptied ID/EX); if asserted, it is ignored.
- Output exclusivity: if_id_stall and if_id_bubble are never both 1. id_ex_bubble and flush_ex are never both 1.
- Counters:
  - stall_cycles increments on any cycle with pc_stall|freeze_all.
  - Both counters saturate at all-ones and do not wrap.
  - perf_clr wins over an increment in the same cycle.
- Asserting reset_n=0 in DRAIN returns to RUN immediately. A stale response after reset is the fetch unit's responsibility.

Test Plan:
- LDR R1 in ID/EX (regwrite=1, dest=1), ADD R2,R1,R3 in IF/ID (uses_sr1=1, sr1=1), imem_resp=1 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then all 0; stall_cycles=1.
- Same hazard but ADD R2,R3,#1 with sr2=1 and uses_sr2=0 -> no stall. With uses_sr2=1 and sr2=1 -> one-cycle stall.
- EX_MEM_mem_access=1, dmem_resp low for 3 cycles with EX_MEM_br_taken=1 -> freeze_all=1 for 3 cycles, flush_count=0. On the 4th cycle (dmem_resp=1): if_id_bubble=flush_ex=1, flush_count=1.
- br_taken with imem_resp=0, then imem_resp low 2 more cycles, then high -> DRAIN for 3 cycles with pc_stall=if_id_bubble=1; RUN afterwards; flush_count=1, stall_cycles=3.
- CNT_WIDTH=4: hold imem_resp=0 for 20 cycles -> stall_cycles saturates at 15. perf_clr pulse -> 0 next cycle.
- reset_n low mid-DRAIN -> all outputs 0 immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall / flush controller for the LC-3b 5-stage pipeline.
// It covers load-use stalls, imem/dmem wait freezes, and taken-branch flushes.
// It also drains the stale fetch left outstanding by a flush.
// Two saturating performance counters track stall cycles and flushes.
module hazard_stall_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           ID_EX_opcode,    // lc3b_opcode
    input  logic                 ID_EX_regwrite,
    input  logic [2:0]           ID_EX_dest,      // lc3b_reg
    input  logic [2:0]           IF_ID_sr1,       // lc3b_reg
    input  logic [2:0]           IF_ID_sr2,       // lc3b_reg
    input  logic                 IF_ID_uses_sr1,
    input  logic                 IF_ID_uses_sr2,
    input  logic                 EX_MEM_mem_access,
    input  logic                 dmem_resp,
    input  logic                 imem_resp,
    input  logic                 EX_MEM_br_taken,
    input  logic                 perf_clr,
    output logic                 freeze_all,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_bubble,
    output logic                 id_ex_bubble,
    output logic                 flush_ex,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // DRAIN means a pre-flush fetch is still outstanding and its response must be dropped.
    typedef enum logic {RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
    logic                 load, luhaz, dwait, flush_evt;
    logic                 frz, pcs, ifs, ifb, idb, fex;

    assign load  = (ID_EX_opcode == OP_LDB) || (ID_EX_opcode == OP_LDR) ||
                   (ID_EX_opcode == OP_LDI);
    assign luhaz = load && ID_EX_regwrite &&
                   ((IF_ID_uses_sr1 && (ID_EX_dest == IF_ID_sr1)) ||
                    (IF_ID_uses_sr2 && (ID_EX_dest == IF_ID_sr2)));
    assign dwait = EX_MEM_mem_access && !dmem_resp;

    // Next-state and raw control outputs. A dmem wait masks every other event.
    always_comb begin
        state_d   = state_q;
        frz       = 1'b0;
        pcs       = 1'b0;
        ifs       = 1'b0;
        ifb       = 1'b0;
        idb       = 1'b0;
        fex       = 1'b0;
        flush_evt = 1'b0;
        case (state_q)
            RUN: begin
                if (dwait) begin
                    frz = 1'b1;
                    pcs = 1'b1;
                end else if (EX_MEM_br_taken) begin
                    ifb       = 1'b1;
                    fex       = 1'b1;
                    flush_evt = 1'b1;
                    if (!imem_resp) state_d = DRAIN;
                end else if (luhaz) begin
                    // One cycle is enough: ID/EX holds the bubble next cycle.
                    pcs = 1'b1;
                    ifs = 1'b1;
                    idb = 1'b1;
                end else if (!imem_resp) begin
                    pcs = 1'b1;
                    ifb = 1'b1;
                end
            end
            DRAIN: begin
                // A branch cannot be in EX/MEM here, so br_taken is ignored.
                if (dwait) begin
                    frz = 1'b1;
                    pcs = 1'b1;
                end else begin
                    pcs = 1'b1;
                    ifb = 1'b1;
                    if (imem_resp) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Saturating counters. A clear takes precedence over an increment.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (perf_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if ((frz || pcs) && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
            if (flush_evt && (flush_q != '1))    flush_d = flush_q + CNT_ONE;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Controls are forced low while reset is held, even if inputs are active.
    assign freeze_all   = reset_n && frz;
    assign pc_stall     = reset_n && pcs;
    assign if_id_stall  = reset_n && ifs;
    assign if_id_bubble = reset_n && ifb;
    assign id_ex_bubble = reset_n && idb;
    assign flush_ex     = reset_n && fex;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (CNT_WIDTH=4 so saturation is reachable).
module tb_hazard_stall_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam logic [3:0] LDB = 4'b0010, LDR = 4'b0110, LDI = 4'b1010, ADD = 4'b0001;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [3:0] op = '0;
    logic rw = 0, u1 = 0, u2 = 0, mem = 0, dr = 0, ir = 1, br = 0, clr = 0;
    logic [2:0] dst = '0, s1 = '0, s2 = '0;
    logic freeze_all, pc_stall, if_id_stall, if_id_bubble, id_ex_bubble, flush_ex;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_chk = 0, n_fail = 0;
    bit m_drain = 0;
    int m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ID_EX_opcode(op), .ID_EX_regwrite(rw),
        .ID_EX_dest(dst), .IF_ID_sr1(s1), .IF_ID_sr2(s2), .IF_ID_uses_sr1(u1),
        .IF_ID_uses_sr2(u2), .EX_MEM_mem_access(mem), .dmem_resp(dr),
        .imem_resp(ir), .EX_MEM_br_taken(br), .perf_clr(clr),
        .freeze_all(freeze_all), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble), .flush_ex(flush_ex),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Output vector order: {freeze, pc_stall, if_id_stall, if_id_bubble, id_ex_bubble, flush_ex}
    typedef struct packed {
        logic [3:0] op;
        logic       rw;
        logic [2:0] dst, s1, s2;
        logic       u1, u2, mem, dr, ir, br;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t mkv(logic [3:0] o, logic w, logic [2:0] d, logic [2:0] a,
                                 logic [2:0] b, logic ua, logic ub, logic m, logic r,
                                 logic i, logic bt, logic [5:0] e);
        vec_t v;
        v.op = o; v.rw = w; v.dst = d; v.s1 = a; v.s2 = b; v.u1 = ua; v.u2 = ub;
        v.mem = m; v.dr = r; v.ir = i; v.br = bt; v.exp = e;
        return v;
    endfunction

    function automatic logic [5:0] dut_out();
        return {freeze_all, pc_stall, if_id_stall, if_id_bubble, id_ex_bubble, flush_ex};
    endfunction

    // Reference: the priority rules evaluated directly on the current inputs.
    function automatic logic [5:0] ref_out(bit drain);
        bit load, haz, dw;
        load = (op == LDB) || (op == LDR) || (op == LDI);
        haz  = load && rw && ((u1 && dst == s1) || (u2 && dst == s2));
        dw   = mem && !dr;
        if (drain) return dw ? 6'b110000 : 6'b010100;
        if (dw)    return 6'b110000;
        if (br)    return 6'b000101;
        if (haz)   return 6'b011010;
        if (!ir)   return 6'b010100;
        return 6'b000000;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        op = v.op; rw = v.rw; dst = v.dst; s1 = v.s1; s2 = v.s2; u1 = v.u1; u2 = v.u2;
        mem = v.mem; dr = v.dr; ir = v.ir; br = v.br;
    endtask

    task automatic idle();
        apply(mkv(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b0));
        clr = 0;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit use_tbl, input logic [5:0] etbl, input string nm);
        logic [5:0] e;
        bit dw;
        @(negedge clk);
        e = ref_out(m_drain);
        chk({nm, ".outs"}, 16'(dut_out()), 16'(e));
        if (use_tbl) chk({nm, ".tbl"}, 16'(dut_out()), 16'(etbl));
        chk({nm, ".stall_cycles"}, 16'(stall_cycles), 16'(m_stall));
        chk({nm, ".flush_count"}, 16'(flush_count), 16'(m_flush));
        chk({nm, ".excl"}, 16'((if_id_stall & if_id_bubble) | (id_ex_bubble & flush_ex)), 16'd0);
        @(posedge clk);
        dw = mem && !dr;
        if (clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if ((e[5] || e[4]) && m_stall < CMAX) m_stall++;
            if (!m_drain && !dw && br && m_flush < CMAX) m_flush++;
        end
        if (m_drain) m_drain = !(ir && !dw);
        else         m_drain = !dw && br && !ir;
        #1;
    endtask

    task automatic model_reset();
        m_drain = 0; m_stall = 0; m_flush = 0;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mkv(LDR, 1, 1, 1, 3, 1, 0, 0, 0, 1, 0, 6'b011010); // LDR R1 / ADD R2,R1,R3
        tbl[1]  = mkv(ADD, 0, 0, 1, 3, 1, 0, 0, 0, 1, 0, 6'b000000); // bubble in ID/EX
        tbl[2]  = mkv(LDR, 1, 1, 3, 1, 1, 0, 0, 0, 1, 0, 6'b000000); // ADD imm: sr2 unused
        tbl[3]  = mkv(LDR, 1, 1, 3, 1, 1, 1, 0, 0, 1, 0, 6'b011010); // sr2 used
        tbl[4]  = mkv(LDB, 0, 2, 2, 0, 1, 0, 0, 0, 1, 0, 6'b000000); // no regwrite
        tbl[5]  = mkv(LDI, 1, 5, 0, 5, 0, 1, 0, 0, 1, 0, 6'b011010); // LDI via sr2
        tbl[6]  = mkv(ADD, 1, 4, 4, 4, 1, 1, 0, 0, 1, 0, 6'b000000); // not a load
        tbl[7]  = mkv(LDR, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 6'b110000); // dwait beats all
        tbl[8]  = mkv(LDR, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 6'b000101); // branch beats hazard
        tbl[9]  = mkv(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010100); // imem wait
        tbl[10] = mkv(LDR, 1, 6, 6, 0, 1, 0, 0, 0, 0, 0, 6'b011010); // hazard beats imem wait
        tbl[11] = mkv(ADD, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b000000); // dmem responding

        // Reset state: active inputs, outputs must still be 0.
        apply(mkv(LDR, 1, 1, 1, 0, 1, 0, 1, 0, 0, 1, 6'b0));
        #2;
        chk("reset.outs", 16'(dut_out()), 16'd0);
        chk("reset.stall", 16'(stall_cycles), 16'd0);
        chk("reset.flush", 16'(flush_count), 16'd0);
        idle();
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            tick(1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Branch held behind a dmem wait: frozen 3 cycles, then the flush.
        idle(); clr = 1; tick(0, 0, "clr0"); clr = 0;
        apply(mkv(ADD, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6'b0));
        for (int i = 0; i < 3; i++) tick(1, 6'b110000, "dw_br");
        chk("dw_br.flush0", 16'(flush_count), 16'd0);
        dr = 1; tick(1, 6'b000101, "dw_br_go");
        idle(); tick(1, 6'b000000, "dw_br_after");
        chk("dw_br.flush1", 16'(flush_count), 16'd1);

        // Flush with an outstanding fetch: DRAIN for 3 cycles.
        clr = 1; tick(0, 0, "clr1"); clr = 0;
        br = 1; ir = 0; tick(1, 6'b000101, "drain_br");
        br = 0; tick(1, 6'b010100, "drain1"); tick(1, 6'b010100, "drain2");
        ir = 1; tick(1, 6'b010100, "drain3");
        tick(1, 6'b000000, "drain_run");
        chk("drain.flush", 16'(flush_count), 16'd1);
        chk("drain.stall", 16'(stall_cycles), 16'd3);

        // dwait inside DRAIN freezes and keeps draining; branch is ignored.
        br = 1; ir = 0; tick(1, 6'b000101, "drw_br");
        mem = 1; dr = 0; ir = 1; tick(1, 6'b110000, "drw_frz");
        mem = 0; br = 1; tick(1, 6'b010100, "drw_end");
        br = 0; tick(1, 6'b000000, "drw_run");

        // Saturation of stall_cycles, then a clear.
        clr = 1; tick(0, 0, "clr2"); clr = 0;
        ir = 0;
        for (int i = 0; i < 20; i++) tick(1, 6'b010100, "sat");
        chk("sat.value", 16'(stall_cycles), 16'd15);
        clr = 1; tick(0, 0, "sat_clr"); clr = 0;
        chk("sat.cleared", 16'(stall_cycles), 16'd0);

        // Reset asserted in DRAIN.
        idle(); br = 1; ir = 0; tick(1, 6'b000101, "rst_br");
        br = 0; #2 reset_n = 0; #1;
        model_reset();
        chk("rstdrain.outs", 16'(dut_out()), 16'd0);
        chk("rstdrain.stall", 16'(stall_cycles), 16'd0);
        chk("rstdrain.flush", 16'(flush_count), 16'd0);
        idle();
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;
        br = 1; ir = 1; tick(1, 6'b000101, "rst_run");   // in DRAIN this would be 010100

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 2000; i++) begin
            op  = ($urandom_range(0, 1) == 1) ? ((($urandom_range(0, 2) == 0) ? LDB :
                  (($urandom_range(0, 1) == 0) ? LDR : LDI))) : 4'($urandom_range(0, 15));
            rw  = 1'($urandom_range(0, 3) != 0);
            dst = 3'($urandom_range(0, 3));
            s1  = 3'($urandom_range(0, 3));
            s2  = 3'($urandom_range(0, 3));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            mem = 1'($urandom_range(0, 2) == 0);
            dr  = 1'($urandom_range(0, 1));
            ir  = 1'($urandom_range(0, 3) != 0);
            br  = 1'($urandom_range(0, 4) == 0);
            clr = 1'($urandom_range(0, 40) == 0);
            tick(0, 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
